// File: rtl/cwm_timer_pkg.sv
// Shared types and default parameters for the countdown timer.
// Used by countdown_timer and tick_prescaler.
package cwm_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_TICK_DIV = 1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by TICK_DIV into single-cycle ticks.
// clear restarts the divider from zero.
module tick_prescaler
  import cwm_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  assign tick = enable & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled ticks and one-cycle expiry pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic (auto-reload) operation.
module countdown_timer
  import cwm_timer_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             stop,
  output logic [WIDTH-1:0] count_out,
  output logic             busy,
  output logic             expired
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             exp_q, exp_d;
  logic             load_acc;
  logic             tick;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  assign load_ready = (state_q == ST_IDLE) |
                      (state_q == ST_EXPIRED);
  assign busy      = (state_q == ST_RUN);
  assign count_out = count_q;
  assign expired   = exp_q;
  assign load_acc  = load_valid & load_ready;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_psc (
    .clk    (clk),
    .rst    (rst),
    .clear  (load_acc),
    .enable (enable & busy),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    exp_d   = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load_acc) begin
      count_d = load_value;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_d = load_value;
`endif
      if (load_value == '0) begin
        state_d = ST_EXPIRED;
        exp_d   = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (busy) begin
      // stop wins over a same-cycle tick
      if (stop) begin
        state_d = ST_IDLE;
        count_d = '0;
      end else if (tick) begin
        if (count_q > WIDTH'(1)) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          exp_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          count_d = reload_q;
`else
          count_d = '0;
          state_d = ST_EXPIRED;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      exp_q   <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      exp_q   <= exp_d;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter: the consumer-side counterpart of the free-running up counter.
- Accepts a start value over a valid/ready load handshake, then decrements it on prescaled enable ticks.
- Signals expiry with a one-cycle pulse.
- Used as the delay/timeout source for downstream sequencers such as light and dice FSMs.

Parameters:
- WIDTH, 8, width of load_value and count_out.
- TICK_DIV, 1, number of enabled cycles per decrement; legal range is 1 to 255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset: one clock; reset is synchronous and active-low.
- load_valid  input  1  load_value is valid this cycle.
- load_ready  output  1  timer can accept a load (state IDLE or EXPIRED).
- load_value  input  WIDTH  start count.
- enable  input  1  advance prescaler/count when 1; freeze when 0.
- stop  input  1  abort a running count.
- count_out  output  WIDTH  current count.
- busy  output  1  state is RUN.
- expired  output  1  one-cycle expiry pulse.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, count_out=0, expired=0, busy=0, prescaler=0, reload register=0.
  - load_ready=1 the cycle after reset.
  - Reset overrides all other inputs, including mid-RUN.
- States:
  - IDLE: count_out holds its value.
  - RUN: counting.
  - EXPIRED: count_out=0, waiting for the next load.
- load_ready is decoded from state (IDLE or EXPIRED); it is 0 in RUN. load_valid in RUN is ignored; no buffering.
- Load accepted (load_valid & load_ready at edge N), after edge N:
  - count_out=load_value.
  - Reload register=load_value.
  - Prescaler cleared.
  - State=RUN if load_value!=0.
  - If load_value==0: state=EXPIRED and expired=1 for one cycle.
- Tick: enable=1 in RUN and prescaler==TICK_DIV-1.
  - Prescaler wraps to 0 on a tick, else increments when enable=1; holds when enable=0.
  - With TICK_DIV=1 every enabled RUN cycle is a tick.
  - First decrement occurs at edge N+TICK_DIV if enable is held at 1.
- Tick with count_out>1: count_out decrements by 1.
- Tick with count_out==1:
  - count_out=0, state=EXPIRED.
  - expired=1 for exactly the following cycle, coincident with count_out==0.
- stop=1 in RUN:
  - Next state IDLE, count_out=0, no expired pulse.
  - stop has priority over a same-cycle tick.
  - stop outside RUN has no effect.
- expired is registered and is never high for two consecutive cycles unless two separate expiry events occur back to back.
- Load accepted in EXPIRED on the same cycle expired is high: the load takes effect normally and expired drops the next cycle.
- No wrap-around below 0: count_out never decrements past 0.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined: a tick with count_out==1 loads count_out from the reload register, pulses expired, and stays in RUN (periodic timer).
  - load_ready stays 0 until stop returns the timer to IDLE.
  - A load_value of 0 still goes to EXPIRED, with no reload.
- Undefined: one-shot behaviour exactly as specified above.

Decomposition:
- Shared package cwm_timer_pkg:
  - State typedef (IDLE, RUN, EXPIRED as a 2-bit enum).
  - Default WIDTH/TICK_DIV constants.
- One sub-module: tick_prescaler.
  - Parameter TICK_DIV; inputs clk, rst, clear, enable; output tick.
  - Instantiated once, with clear driven by load acceptance.

Test Plan:
- Reset check: rst=0 for 2 cycles during RUN with count_out=0x37 -> count_out=0, busy=0, load_ready=1, expired=0.
- One-shot, TICK_DIV=1: load 5, enable=1 -> count_out 5,4,3,2,1,0 on consecutive cycles; expired high only in the cycle count_out==0; load_ready rises in that same cycle.
- Prescale and freeze, TICK_DIV=4: load 3 with enable toggling 1,1,0,1,1 -> count_out reaches 2 only after 4 enabled cycles; no change while enable=0.
- Stop/ignored-load:
  - During RUN at count_out=9, load_valid=1 with value 0xAA -> ignored.
  - Then stop=1 -> IDLE, count_out=0, no expired pulse.
- Zero load and back-to-back: load 0 -> expired pulse next cycle, state EXPIRED; immediately load 2 -> expiry two ticks later, pulses not merged.
- With COUNTDOWN_AUTO_RELOAD_EN: load 3, enable=1 for 10 cycles -> count_out 3,2,1,3,2,1,3,...; expired pulses every 3rd cycle; stop returns to IDLE.
